// File: rtl/bp_size_arb.sv
// Round-robin arbiter sharing one BP block-size decoder among NUM_SSM substreams.
// Define BP_SIZE_STAT_EN to add per-lane saturating size accumulators on stat_bits.
module bp_size_arb #(
    parameter int NUM_SSM  = 4,
    parameter int SUFFIX_W = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SSM-1:0]          req_valid,
    output logic [NUM_SSM-1:0]          req_ready,
    input  logic [NUM_SSM*SUFFIX_W-1:0] req_suffix,
    input  logic [NUM_SSM-1:0]          req_use2x2,
    input  logic [NUM_SSM-1:0]          req_isFls,
    output logic [SUFFIX_W-1:0]         dp_suffix,
    output logic                        dp_use2x2,
    output logic                        dp_isFls,
    output logic                        dp_mode_BP,
    input  logic [7:0]                  dp_bp_size,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [1:0]                  resp_idx,
    output logic [7:0]                  resp_size,
    output logic                        resp_err
`ifdef BP_SIZE_STAT_EN
    ,
    output logic [NUM_SSM*16-1:0]       stat_bits
`endif
);

    localparam int IDX_W = (NUM_SSM > 1) ? $clog2(NUM_SSM) : 1;
    localparam int CW    = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    rr_ptr_d;
    logic [IDX_W-1:0]    lane_q;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_found;
    logic                grant_en;
    logic                accept_resp;
    logic                size_err;
    logic [SUFFIX_W-1:0] dp_suffix_q;
    logic                dp_use2x2_q;
    logic                dp_isFls_q;
    logic                dp_mode_q;
    logic                resp_valid_q;
    logic [1:0]          resp_idx_q;
    logic [7:0]          resp_size_q;
    logic                resp_err_q;

    // Search from rr_ptr upward, wrapping at NUM_SSM, for the first valid lane.
    always_comb begin
        logic [CW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_SSM; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= CW'(NUM_SSM)) begin
                cand = cand - CW'(NUM_SSM);
            end
            if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign rr_ptr_d    = (grant_idx == IDX_W'(NUM_SSM - 1)) ? '0 : grant_idx + IDX_W'(1);
    assign accept_resp = (state_q == RESP) && resp_ready;
    assign grant_en    = !rst && ((state_q == IDLE) || accept_resp);
    assign size_err    = 32'(dp_bp_size) > 32'(SUFFIX_W);

    always_comb begin
        req_ready = '0;
        if (grant_en && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            lane_q       <= '0;
            dp_suffix_q  <= '0;
            dp_use2x2_q  <= 1'b0;
            dp_isFls_q   <= 1'b0;
            dp_mode_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_idx_q   <= '0;
            resp_size_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    if (accept_resp) begin
                        resp_valid_q <= 1'b0;
                    end
                    if (grant_en && grant_found) begin
                        state_q     <= ISSUE;
                        rr_ptr_q    <= rr_ptr_d;
                        lane_q      <= grant_idx;
                        dp_suffix_q <= req_suffix[grant_idx*SUFFIX_W +: SUFFIX_W];
                        dp_use2x2_q <= req_use2x2[grant_idx];
                        dp_isFls_q  <= req_isFls[grant_idx];
                        dp_mode_q   <= 1'b1;
                    end else if (accept_resp) begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    // Decoder output is combinational on dp_suffix, which has been stable since ISSUE.
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_idx_q   <= 2'(lane_q);
                    resp_size_q  <= dp_bp_size;
                    resp_err_q   <= size_err;
                    dp_mode_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dp_suffix  = dp_suffix_q;
    assign dp_use2x2  = dp_use2x2_q;
    assign dp_isFls   = dp_isFls_q;
    assign dp_mode_BP = dp_mode_q;
    assign resp_valid = resp_valid_q;
    assign resp_idx   = resp_idx_q;
    assign resp_size  = resp_size_q;
    assign resp_err   = resp_err_q;

`ifdef BP_SIZE_STAT_EN
    logic [NUM_SSM-1:0][15:0] stat_q;
    logic [16:0]              stat_sum;

    // lane_q still names the responding lane until the next grant edge.
    assign stat_sum = {1'b0, stat_q[lane_q]} + 17'(resp_size_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else if (accept_resp) begin
            stat_q[lane_q] <= stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
        end
    end

    assign stat_bits = stat_q;
`endif

endmodule

// File: tb/tb_bp_size_arb.sv
// Self-checking bench for bp_size_arb: table-driven single requests, multi-cycle
// sequences, and a scoreboard matching grants and responses against pushed expectations.
`timescale 1ns/1ps
module tb_bp_size_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [511:0] req_suffix;
    logic [3:0]   req_use2x2;
    logic [3:0]   req_isFls;
    logic [127:0] dp_suffix;
    logic         dp_use2x2;
    logic         dp_isFls;
    logic         dp_mode_BP;
    logic [7:0]   dp_bp_size;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_idx;
    logic [7:0]   resp_size;
    logic         resp_err;
`ifdef BP_SIZE_STAT_EN
    logic [63:0]  stat_bits;
`endif

    typedef struct {
        logic [3:0] valid;
        logic [7:0] size;
        logic       use2x2;
        logic       isFls;
        logic [1:0] expIdx;
        logic       expErr;
    } vec_t;

    typedef struct {
        logic [1:0]   idx;
        logic [7:0]   size;
        logic         err;
        logic         use2x2;
        logic         isFls;
        logic [127:0] suf;
    } exp_t;

    exp_t         expQ[$];
    exp_t         cur;
    int           grantCycQ[$];
    logic [127:0] laneSuf[4];
    vec_t         vecs[7];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           grantCount = 0;
    int           due = 0;
    int           grantCyc = 0;
    bit           inFlight = 1'b0;
    bit           dueChecked = 1'b0;

    always #5 clk = ~clk;

    // Stand-in for the shared size decoder: the block size is the leading suffix byte.
    assign dp_bp_size = dp_suffix[127:120];

    bp_size_arb #(.NUM_SSM(4), .SUFFIX_W(128)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_suffix(req_suffix),
        .req_use2x2(req_use2x2),
        .req_isFls(req_isFls),
        .dp_suffix(dp_suffix),
        .dp_use2x2(dp_use2x2),
        .dp_isFls(dp_isFls),
        .dp_mode_BP(dp_mode_BP),
        .dp_bp_size(dp_bp_size),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_idx(resp_idx),
        .resp_size(resp_size),
        .resp_err(resp_err)
`ifdef BP_SIZE_STAT_EN
        ,
        .stat_bits(stat_bits)
`endif
    );

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: a grant pops the next expectation; responses are compared every valid cycle.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            inFlight = 1'b0;
        end else begin
            if (resp_valid) begin
                if (!inFlight) begin
                    checkOutput("spurious_resp", 128'(resp_valid), 128'(0));
                end else begin
                    if (!dueChecked) begin
                        checkOutput("resp_latency", 128'(cyc), 128'(due));
                        dueChecked = 1'b1;
                    end
                    checkOutput("resp_fields", 128'({resp_idx, resp_size, resp_err}),
                                128'({cur.idx, cur.size, cur.err}));
                    checkOutput("resp_mode_low", 128'(dp_mode_BP), 128'(0));
                    if (resp_ready) begin
                        inFlight = 1'b0;
                    end else begin
                        checkOutput("no_grant_backpressure", 128'(req_ready), 128'(0));
                    end
                end
            end
            if (req_ready != 4'b0000) begin
                checkOutput("grant_subset", 128'(req_ready & ~req_valid), 128'(0));
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_grant", 128'(req_ready), 128'(0));
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("grant_lane", 128'(req_ready), 128'(4'b0001 << cur.idx));
                    inFlight   = 1'b1;
                    dueChecked = 1'b0;
                    due        = cyc + 3;
                    grantCyc   = cyc;
                    grantCount++;
                    grantCycQ.push_back(cyc);
                end
            end
            if (inFlight && cyc == grantCyc + 1) begin
                checkOutput("issue_ctrl", 128'({dp_mode_BP, dp_use2x2, dp_isFls}),
                            128'({1'b1, cur.use2x2, cur.isFls}));
                checkOutput("issue_suffix", dp_suffix, cur.suf);
            end
        end
    end

    task automatic setLane(input int lane, input logic [7:0] size);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        laneSuf[lane] = {size, r[119:0]};
        req_suffix[lane*128 +: 128] = laneSuf[lane];
    endtask

    task automatic pushLane(input int lane, input logic u2, input logic fls);
        exp_t e;
        e.idx    = 2'(lane);
        e.size   = laneSuf[lane][127:120];
        e.err    = (laneSuf[lane][127:120] > 8'd128);
        e.use2x2 = u2;
        e.isFls  = fls;
        e.suf    = laneSuf[lane];
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [3:0] sel;
        exp_t e;
        sel = 4'b0001 << v.expIdx;
        for (int i = 0; i < 4; i++) setLane(i, v.size);
        req_use2x2 = v.use2x2 ? sel : ~sel;
        req_isFls  = v.isFls ? sel : ~sel;
        e.idx    = v.expIdx;
        e.size   = v.size;
        e.err    = v.expErr;
        e.use2x2 = v.use2x2;
        e.isFls  = v.isFls;
        e.suf    = laneSuf[v.expIdx];
        expQ.push_back(e);
        req_valid = v.valid;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while ((expQ.size() != 0 || inFlight) && n < 30);
        if (expQ.size() != 0 || inFlight) begin
            reportTimeout(name);
            expQ.delete();
        end
        #1;
    endtask

    task automatic resetDut();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ctrl", 128'({req_ready, resp_valid, resp_idx, resp_size, resp_err,
                                        dp_use2x2, dp_isFls, dp_mode_BP}), 128'(0));
        checkOutput("reset_suffix", dp_suffix, 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Request, expect the grant in the very first cycle, then change inputs to prove capture.
    task automatic runVector(input vec_t v);
        int g0;
        g0 = grantCount;
        applyStimulus(v);
        @(posedge clk);
        checkOutput("first_cycle_grant", 128'(grantCount - g0), 128'(1));
        #1;
        req_valid = '0;
        for (int i = 0; i < 4; i++) req_suffix[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        req_use2x2 = ~req_use2x2;
        req_isFls  = ~req_isFls;
        waitIdle("vector_done");
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        int   g0;
        int   n;
        rst        = 1'b1;
        req_valid  = '0;
        req_suffix = '0;
        req_use2x2 = '0;
        req_isFls  = '0;
        resp_ready = 1'b1;

        vecs[0] = '{4'b0100, 8'd45,  1'b0, 1'b1, 2'd2, 1'b0};
        vecs[1] = '{4'b1111, 8'd128, 1'b1, 1'b0, 2'd3, 1'b0};
        vecs[2] = '{4'b1111, 8'd129, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[3] = '{4'b0001, 8'd200, 1'b1, 1'b1, 2'd0, 1'b1};
        vecs[4] = '{4'b1010, 8'd0,   1'b1, 1'b1, 2'd1, 1'b0};
        vecs[5] = '{4'b1001, 8'd127, 1'b0, 1'b1, 2'd3, 1'b0};
        vecs[6] = '{4'b0110, 8'd255, 1'b1, 1'b0, 2'd1, 1'b1};

        resetDut();
        for (int i = 0; i < 7; i++) runVector(vecs[i]);

        // All lanes requesting continuously: grants 0,1,2,3,0 three cycles apart.
        resetDut();
        for (int i = 0; i < 4; i++) setLane(i, 8'(30 + i * 40));
        req_use2x2 = 4'b0101;
        req_isFls  = 4'b0011;
        pushLane(0, 1'b1, 1'b1);
        pushLane(1, 1'b0, 1'b1);
        pushLane(2, 1'b1, 1'b0);
        pushLane(3, 1'b0, 1'b0);
        pushLane(0, 1'b1, 1'b1);
        grantCycQ.delete();
        g0 = grantCount;
        req_valid = 4'b1111;
        n = 0;
        while (grantCount < g0 + 5 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        req_valid = '0;
        if (grantCount < g0 + 5) reportTimeout("rr_stream");
        waitIdle("rr_stream_done");
        checkOutput("rr_grants", 128'(grantCycQ.size()), 128'(5));
        for (int i = 1; i < grantCycQ.size(); i++)
            checkOutput("rr_spacing", 128'(grantCycQ[i] - grantCycQ[i-1]), 128'(3));

        // Backpressure: response held, competing request waits, grant on the ready cycle.
        resetDut();
        setLane(1, 8'd77);
        setLane(3, 8'd99);
        req_use2x2 = 4'b0010;
        req_isFls  = 4'b1000;
        pushLane(1, 1'b1, 1'b0);
        req_valid  = 4'b0010;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 10);
        checkOutput("bp_resp_arrives", 128'(resp_valid), 128'(1));
        @(posedge clk);
        #1;
        pushLane(3, 1'b0, 1'b1);
        req_valid = 4'b1000;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", 128'(resp_valid), 128'(1));
            checkOutput("bp_no_ready", 128'(req_ready), 128'(0));
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_grant_on_ready", 128'(req_ready), 128'(4'b1000));
        @(posedge clk);
        #1;
        req_valid = '0;
        waitIdle("bp_done");

        // Reset while the block is in CAPTURE: nothing comes out and arbitration restarts at lane 0.
        resetDut();
        setLane(2, 8'd60);
        req_use2x2 = '0;
        req_isFls  = '0;
        pushLane(2, 1'b0, 1'b0);
        req_valid = 4'b0100;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_ctrl", 128'({req_ready, resp_valid, resp_idx, resp_size, resp_err,
                                        dp_use2x2, dp_isFls, dp_mode_BP}), 128'(0));
        checkOutput("abort_suffix", dp_suffix, 128'(0));
        repeat (4) begin
            @(negedge clk);
            checkOutput("abort_no_resp", 128'(resp_valid), 128'(0));
        end
        @(posedge clk);
        #1;
        v = '{4'b1111, 8'd10, 1'b0, 1'b0, 2'd0, 1'b0};
        runVector(v);

`ifdef BP_SIZE_STAT_EN
        resetDut();
        v = '{4'b0010, 8'd200, 1'b0, 1'b0, 2'd1, 1'b1};
        runVector(v);
        v.size   = 8'd100;
        v.expErr = 1'b0;
        runVector(v);
        checkOutput("stat_sum", 128'(stat_bits[31:16]), 128'(300));
        v.size   = 8'd255;
        v.expErr = 1'b1;
        for (int i = 0; i < 260; i++) runVector(v);
        checkOutput("stat_saturate", 128'(stat_bits[31:16]), 128'(16'hFFFF));
        checkOutput("stat_other_lanes", 128'({stat_bits[63:32], stat_bits[15:0]}), 128'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_size_arb.md
BP_SIZE_ARB -- requirements
Module: bp_size_arb

Interface
REQ-001 Parameter NUM_SSM, default 4: number of substream requesters sharing one BP block-size decode datapath.
REQ-002 Parameter SUFFIX_W, default 128: suffix window width per requester, in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NUM_SSM  per-substream request to size one BP block.
REQ-006 req_ready  output  NUM_SSM  one-hot grant pulse; request i is accepted in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-007 req_suffix  input  NUM_SSM*SUFFIX_W  flat suffix windows; substream i occupies bits [i*SUFFIX_W +: SUFFIX_W], MSB-first bitstream.
REQ-008 req_use2x2  input  NUM_SSM  per-substream 2x2 BPV partition select.
REQ-009 req_isFls  input  NUM_SSM  per-substream first-line-of-slice flag.
REQ-010 dp_suffix  output  SUFFIX_W  registered suffix driven to the shared size decoder.
REQ-011 dp_use2x2, dp_isFls, dp_mode_BP  output  1 each  registered datapath controls.
REQ-012 dp_bp_size  input  8  combinational block size (BPV bits plus coefficient bits) returned by the shared decoder.
REQ-013 resp_valid  output  1  response holding.
REQ-014 resp_ready  input  1  consumer accepts the response.
REQ-015 resp_idx  output  2  substream index of the response.
REQ-016 resp_size  output  8  captured dp_bp_size.
REQ-017 resp_err  output  1  high when resp_size > SUFFIX_W.

Function
REQ-018 FSM states: IDLE, ISSUE, CAPTURE, RESP.
REQ-019 IDLE: if any req_valid, grant per REQ-024, load the dp_* registers from the granted lane, go to ISSUE; otherwise stay in IDLE.
REQ-020 ISSUE: dp_mode_BP=1; go to CAPTURE unconditionally.
REQ-021 CAPTURE: register dp_bp_size into resp_size, set resp_err, go to RESP.
REQ-022 RESP: resp_valid=1; resp_idx, resp_size and resp_err stay stable until resp_ready.
- On resp_ready with any req_valid: grant in the same cycle and go to ISSUE.
- On resp_ready with no req_valid: go to IDLE.
REQ-023 Latency: a request accepted in cycle T gives resp_valid in cycle T+3; sustained throughput is one block per 3 cycles while resp_ready is held high.
REQ-024 Arbitration is round-robin:
- Search starts at rr_ptr and wraps from NUM_SSM-1 to 0.
- After a grant to lane g, rr_ptr = (g+1) mod NUM_SSM.
- At most one req_ready bit is high per cycle, and only in IDLE or in an accepting RESP cycle.
REQ-025 req_ready is never asserted for a lane whose req_valid is low.
REQ-026 The granted lane's suffix, use2x2 and isFls are captured at grant; later changes on req_* do not affect the in-flight block.
REQ-027 dp_mode_BP is 0 in IDLE and RESP; the dp_* data registers hold their last values outside ISSUE and CAPTURE.
REQ-028 resp_err compares the 8-bit resp_size against SUFFIX_W as unsigned; resp_size equal to SUFFIX_W is not an error.
REQ-029 A request that deasserts before it is granted is dropped without side effects.

Reset
REQ-030 While rst is high at a clock edge:
- state=IDLE, rr_ptr=0;
- req_ready=0, resp_valid=0, resp_idx=0, resp_size=0, resp_err=0;
- dp_suffix=0, dp_use2x2=0, dp_isFls=0, dp_mode_BP=0.
REQ-031 Reset in ISSUE, CAPTURE or RESP discards the in-flight block; no response is produced for it.
REQ-032 The first grant can occur in the first cycle after rst deasserts.

Configuration
REQ-033 Macro BP_SIZE_STAT_EN, when defined:
- adds output stat_bits (NUM_SSM*16 bits), one 16-bit accumulator per lane;
- a lane's accumulator adds resp_size on each accepted response (resp_valid and resp_ready) for that lane;
- accumulators saturate at 16'hFFFF;
- accumulators reset to 0 on rst.
REQ-034 When BP_SIZE_STAT_EN is undefined, the port and the accumulators are absent, and all other behaviour is identical.

Verification
REQ-035 Single request, lane 2 valid, dp_bp_size=8'd45, resp_ready=1 -> req_ready=4'b0100 at T; resp_valid at T+3 with idx=2, size=45, err=0.
REQ-036 All four lanes valid continuously, resp_ready=1, from reset -> grant order 0,1,2,3,0 at 3-cycle spacing.
REQ-037 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid held with stable idx and size; no req_ready pulses; grant occurs in the same cycle resp_ready rises.
REQ-038 Error boundary: dp_bp_size=128 -> err=0; dp_bp_size=129 -> err=1.
REQ-039 Reset asserted in CAPTURE -> next cycle all outputs 0 and state IDLE; no response for the aborted block; the next grant starts at lane 0.
REQ-040 With BP_SIZE_STAT_EN defined: lane 1 accepted with sizes 200 and 100 -> stat_bits lane 1 = 300; an accumulation pushing past 65535 -> lane 1 value = 16'hFFFF.
